// File: rtl/riscv_pkg.sv
// Shared RV32 decode constants and the M-extension sequencer state encoding.
package riscv_pkg;

    localparam int unsigned MD_DATA_W = 32;
    localparam int unsigned MD_CNT_W  = 6;

    localparam logic [6:0] OPC_ARITHMETIC = 7'b0110011;
    localparam logic [6:0] OPC_ARITH_IMM  = 7'b0010011;
    localparam logic [6:0] FUNCT7_MULDIV  = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } md_state_e;

    // Decoder helper: R-type with the M-extension funct7.
    function automatic logic is_muldiv(input logic [6:0] opcode, input logic [6:0] funct7);
        return (opcode == OPC_ARITHMETIC) && (funct7 == FUNCT7_MULDIV);
    endfunction

    function automatic logic is_arith_imm(input logic [6:0] opcode);
        return opcode == OPC_ARITH_IMM;
    endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Iterative shift-add multiplier / restoring divider sharing one {hi,lo} register pair.
module muldiv_datapath
    import riscv_pkg::*;
#(
    parameter int unsigned DATA_W = MD_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              step_i,
    input  logic [2:0]        funct3_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] result_c_o
);

    localparam int unsigned PW = 2 * DATA_W;

    logic [2:0]        op_q,  op_d;
    logic              neg_q, neg_d;
    logic [DATA_W-1:0] m_q,   m_d;
    logic [DATA_W-1:0] hi_q,  hi_d;
    logic [DATA_W-1:0] lo_q,  lo_d;

    logic              signed_a, signed_b, sa, sb;
    logic [DATA_W-1:0] a_mag, b_mag;
    logic [DATA_W:0]   sum, shifted, diff;
    logic [PW-1:0]     prod, prod_s;
    logic [DATA_W-1:0] quo_s, rem_s;

    // Operand signedness and magnitudes for the incoming request.
    always_comb begin
        signed_a = funct3_i inside {F3_MUL, F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
        signed_b = funct3_i inside {F3_MUL, F3_MULH, F3_DIV, F3_REM};
        sa       = signed_a & a_i[DATA_W-1];
        sb       = signed_b & b_i[DATA_W-1];
        a_mag    = sa ? (~a_i + DATA_W'(1)) : a_i;
        b_mag    = sb ? (~b_i + DATA_W'(1)) : b_i;
    end

    // Start loads operands; each step performs one multiply or divide iteration.
    always_comb begin
        op_d    = op_q;
        neg_d   = neg_q;
        m_d     = m_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
        shifted = {hi_q, lo_q[DATA_W-1]};
        diff    = shifted - {1'b0, m_q};
        if (start_i) begin
            op_d = funct3_i;
            m_d  = funct3_i[2] ? b_mag : a_mag;
            if (funct3_i[2] && (b_i == '0)) begin
                // Zero divisor: final quotient/remainder preloaded, never negated.
                neg_d = 1'b0;
                hi_d  = a_i;
                lo_d  = '1;
            end else if (funct3_i[2]) begin
                neg_d = funct3_i[1] ? sa : (sa ^ sb);
                hi_d  = '0;
                lo_d  = a_mag;
            end else begin
                neg_d = sa ^ sb;
                hi_d  = '0;
                lo_d  = b_mag;
            end
        end else if (step_i) begin
            if (op_q[2]) begin
                if (!diff[DATA_W]) begin
                    hi_d = diff[DATA_W-1:0];
                    lo_d = {lo_q[DATA_W-2:0], 1'b1};
                end else begin
                    hi_d = shifted[DATA_W-1:0];
                    lo_d = {lo_q[DATA_W-2:0], 1'b0};
                end
            end else begin
                hi_d = sum[DATA_W:1];
                lo_d = {sum[0], lo_q[DATA_W-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q  <= '0;
            neg_q <= 1'b0;
            m_q   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            op_q  <= op_d;
            neg_q <= neg_d;
            m_q   <= m_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
        end
    end

    // Final sign fix-up and half/quotient/remainder selection.
    always_comb begin
        prod   = {hi_q, lo_q};
        prod_s = neg_q ? (~prod + PW'(1)) : prod;
        quo_s  = neg_q ? (~lo_q + DATA_W'(1)) : lo_q;
        rem_s  = neg_q ? (~hi_q + DATA_W'(1)) : hi_q;
        case (op_q)
            F3_MUL:                       result_c_o = prod_s[DATA_W-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: result_c_o = prod_s[PW-1:DATA_W];
            F3_DIV, F3_DIVU:              result_c_o = quo_s;
            default:                      result_c_o = rem_s;
        endcase
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M controller: accepts one M-op, stalls the pipe for DATA_W iterations, strobes the result.
module muldiv_sequencer
    import riscv_pkg::*;
#(
    parameter int unsigned DATA_W = MD_DATA_W,
    parameter int unsigned CNT_W  = MD_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_i,
    input  logic [2:0]        funct3_i,
    input  logic [DATA_W-1:0] in_A,
    input  logic [DATA_W-1:0] in_B,
    input  logic              flush_i,
    output logic              stall_o,
    output logic              ready_o,
    output logic [DATA_W-1:0] out_o
);

    md_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              start_c, step_c;
    logic [DATA_W-1:0] result_c;
    logic [DATA_W-1:0] out_q;

    muldiv_datapath #(.DATA_W(DATA_W)) u_datapath (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_c),
        .step_i     (step_c),
        .funct3_i   (funct3_i),
        .a_i        (in_A),
        .b_i        (in_B),
        .result_c_o (result_c)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, datapath controls and pipeline stall.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        start_c = 1'b0;
        step_c  = 1'b0;
        stall_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (valid_i && !flush_i) begin
                    start_c = 1'b1;
                    stall_o = 1'b1;
                    cnt_d   = '0;
                    state_d = (funct3_i[2] && (in_B == '0)) ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                stall_o = 1'b1;
                if (flush_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    step_c = 1'b1;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_d = ST_DONE;
                        cnt_d   = '0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Result is held after the strobe; consumers qualify with ready_o.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q <= '0;
        end else if (state_q == ST_DONE) begin
            out_q <= result_c;
        end
    end

    assign ready_o = (state_q == ST_DONE);
    assign out_o   = (state_q == ST_DONE) ? result_c : out_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: vector table, random ops vs. reference model, corner sequences.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_i;
    logic [2:0]  funct3_i;
    logic [31:0] in_A, in_B;
    logic        flush_i;
    logic        stall_o, ready_o;
    logic [31:0] out_o;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[14];

    muldiv_sequencer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid_i  (valid_i),
        .funct3_i (funct3_i),
        .in_A     (in_A),
        .in_B     (in_B),
        .flush_i  (flush_i),
        .stall_o  (stall_o),
        .ready_o  (ready_o),
        .out_o    (out_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_md(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa = a;
        logic signed [31:0] sb = b;
        logic signed [31:0] sr;
        logic signed [63:0] p;
        logic [63:0]        u;
        logic               ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin u = {32'd0, a} * {32'd0, b}; return u[31:0]; end
            3'd1: begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return p[63:32]; end
            3'd2: begin p = $signed({{32{a[31]}}, a}) * $signed({32'd0, b}); return p[63:32]; end
            3'd3: begin u = {32'd0, a} * {32'd0, b}; return u[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                sr = sa / sb;
                return sr;
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (ovf) return 32'd0;
                sr = sa % sb;
                return sr;
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    // Issue one op, wait for the strobe, check latency/stall/result and the hold afterwards.
    task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
        int          cyc;
        logic        stall_ok;
        logic [31:0] e;
        @(negedge clk);
        valid_i = 1'b1; funct3_i = f3; in_A = a; in_B = b;
        exp_q.push_back(exp);
        #1;
        stall_ok = stall_o;
        @(negedge clk);
        valid_i = 1'b0;
        cyc = 1;
        while (!ready_o && cyc < 60) begin
            if (!stall_o) stall_ok = 1'b0;
            @(negedge clk);
            cyc++;
        end
        chk({name, " stall"}, 32'(stall_ok), 32'd1);
        if (!ready_o) begin
            checks++; errors++;
            $display("FAIL %s timeout: no ready_o within %0d cycles", name, cyc);
            void'(exp_q.pop_front());
        end else begin
            chk({name, " latency"}, 32'(cyc), 32'(lat));
            chk({name, " stall@done"}, 32'(stall_o), 32'd0);
            e = exp_q.pop_front();
            chk({name, " result"}, out_o, e);
            @(negedge clk);
            chk({name, " strobe_one_cycle"}, 32'(ready_o), 32'd0);
            chk({name, " hold"}, out_o, e);
        end
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        int          seen;
        logic [2:0]  rf;
        logic [31:0] ra, rb;
        logic [31:0] e;

        vecs[0]  = '{3'd0, 32'd7,          32'd6,          32'h0000_002A, 33};
        vecs[1]  = '{3'd1, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF, 33};
        vecs[2]  = '{3'd3, 32'hFFFF_FFFF,  32'd2,          32'h0000_0001, 33};
        vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF, 33};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD, 33};
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF, 33};
        vecs[6]  = '{3'd5, 32'd100,        32'd7,          32'd14,        33};
        vecs[7]  = '{3'd7, 32'd100,        32'd7,          32'd2,         33};
        vecs[8]  = '{3'd5, 32'd5,          32'd0,          32'hFFFF_FFFF, 1};
        vecs[9]  = '{3'd6, 32'd5,          32'd0,          32'd5,         1};
        vecs[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 33};
        vecs[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,         33};
        vecs[12] = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, 33};
        vecs[13] = '{3'd0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001, 33};

        rst_n = 1'b0; valid_i = 1'b0; flush_i = 1'b0;
        funct3_i = 3'd0; in_A = '0; in_B = '0;
        wait_cycles(3);
        chk("reset ready_o", 32'(ready_o), 32'd0);
        chk("reset out_o",   out_o,        32'd0);
        chk("reset stall_o", 32'(stall_o), 32'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) run_op($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

        for (int i = 0; i < 8; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            e  = ref_md(rf, ra, rb);
            run_op($sformatf("rand%0d f3=%0d", i, rf), rf, ra, rb, e, (rf[2] && rb == 32'd0) ? 1 : 33);
        end

        // Flush in CALC at cycle 10: back to IDLE, no strobe.
        @(negedge clk);
        valid_i = 1'b1; funct3_i = 3'd0; in_A = 32'd3; in_B = 32'd5;
        @(negedge clk);
        valid_i = 1'b0;
        wait_cycles(9);
        flush_i = 1'b1;
        #1 chk("flush stall_in_calc", 32'(stall_o), 32'd1);
        @(negedge clk);
        flush_i = 1'b0;
        chk("flush stall_after", 32'(stall_o), 32'd0);
        chk("flush ready_after", 32'(ready_o), 32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (ready_o) seen++;
            @(negedge clk);
        end
        chk("flush no_strobe", 32'(seen), 32'd0);

        // Valid ignored during CALC; flush in DONE keeps that cycle's strobe.
        @(negedge clk);
        valid_i = 1'b1; funct3_i = 3'd5; in_A = 32'd100; in_B = 32'd7;
        exp_q.push_back(32'd14);
        @(negedge clk);
        valid_i = 1'b0;
        wait_cycles(4);
        valid_i = 1'b1; funct3_i = 3'd0; in_A = 32'd2; in_B = 32'd3;
        @(negedge clk);
        valid_i = 1'b0;
        wait_cycles(27);
        flush_i = 1'b1;
        #1;
        chk("done_flush ready", 32'(ready_o), 32'd1);
        e = exp_q.pop_front();
        chk("done_flush result", out_o, e);
        @(negedge clk);
        flush_i = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (ready_o) seen++;
            @(negedge clk);
        end
        chk("ignored_valid no_strobe", 32'(seen), 32'd0);

        // Reset at cycle 20 of an op, then a fresh op completes normally.
        @(negedge clk);
        valid_i = 1'b1; funct3_i = 3'd0; in_A = 32'd9; in_B = 32'd9;
        @(negedge clk);
        valid_i = 1'b0;
        wait_cycles(19);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midreset ready_o", 32'(ready_o), 32'd0);
        chk("midreset out_o",   out_o,        32'd0);
        chk("midreset stall_o", 32'(stall_o), 32'd0);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (ready_o) seen++;
            @(negedge clk);
        end
        chk("midreset no_strobe", 32'(seen), 32'd0);
        run_op("after_reset", 3'd0, 32'd11, 32'd13, 32'd143, 33);

        chk("scoreboard empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle controller for the RV32M extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
- Sits beside the main ALU in EX. It accepts one operation when the control decoder flags an R-type with funct7=0000001.
- Runs an iterative shift-add / restoring-divide datapath for DATA_W cycles and holds the pipeline stalled meanwhile.
- Returns a single-cycle result strobe to the writeback mux.

Parameters:
- DATA_W, 32, operand/result width; iteration count equals DATA_W.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > DATA_W.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- valid_i  input  1  M-op request from EX (opcode 0110011, funct7 0000001)
- funct3_i  input  3  M-op select, RISC-V encoding (000 MUL … 111 REMU)
- in_A  input  DATA_W  rs1 operand
- in_B  input  DATA_W  rs2 operand
- flush_i  input  1  abort current op (branch/jump taken)
- stall_o  output  1  freeze PC/IF/ID/EX while op pending
- ready_o  output  1  one-cycle strobe: result valid
- out_o  output  DATA_W  result, valid only when ready_o=1

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE, counter=0, all internal registers 0. ready_o=0, out_o=0, stall_o=0. Applies mid-operation; the op is discarded and no ready_o follows.
- States: IDLE, CALC, DONE.
- IDLE:
  - valid_i=1 and flush_i=0: latch funct3, operands, sign flags; counter=0.
  - Next state is CALC, except a divide-class op with in_B==0, which goes directly to DONE (zero-divide short path).
- CALC: one iteration per cycle, counter+1. At counter==DATA_W-1, go to DONE.
- DONE: ready_o=1 and out_o=final result for exactly one cycle. Next state IDLE.
- Latency, request accepted at cycle 0:
  - Normal ops: ready_o at cycle DATA_W+1 (33).
  - Zero-divide: ready_o at cycle 1.
- stall_o = (IDLE & valid_i & ~flush_i) | CALC. It is 0 in DONE so the pipeline advances with the result in the same cycle.
- valid_i is ignored outside IDLE; no queuing.
- flush_i=1 in any state: next state IDLE, no ready_o. flush_i has priority over valid_i and over the DONE strobe only if asserted in CALC; a flush in DONE does not suppress that cycle's strobe.
- Multiply: operands converted to magnitudes per signedness (MUL/MULH signed×signed, MULHSU signed×unsigned, MULHU unsigned). 2·DATA_W-bit product accumulated; result negated if signs differ. MUL returns the low half, others the high half.
- Divide: restoring division on magnitudes. Quotient negated if signs differ (DIV). Remainder takes the dividend's sign (REM).
- Zero divisor: quotient=all ones; remainder=in_A unmodified.
- Overflow DIV 0x80000000/0xFFFFFFFF must yield quotient 0x80000000, remainder 0, by natural arithmetic with no special-case branch.
- out_o holds its value outside DONE; consumers qualify with ready_o.

Decomposition:
- Shared package riscv_pkg:
  - opcode constants (ARITHMETIC etc., matching the control decoder)
  - FUNCT7_MULDIV=7'b0000001
  - funct3 codes F3_MUL…F3_REMU
  - state encoding enum for IDLE/CALC/DONE
- One sub-module muldiv_datapath: operand magnitude/sign logic, accumulator/remainder shift registers, final negation. It is driven by start/step/op controls from the FSM in muldiv_sequencer.

Test Plan:
- MUL in_A=7, in_B=6 -> stall_o high cycles 0–32, ready_o at cycle 33, out_o=0x0000002A.
- in_A=0xFFFFFFFF, in_B=2:
  - MULH -> 0xFFFFFFFF
  - MULHU -> 0x00000001
  - MULHSU -> 0xFFFFFFFF
- DIV in_A=0xFFFFFFF9 (-7), in_B=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
- DIVU in_A=5, in_B=0 -> ready_o at cycle 1, out_o=0xFFFFFFFF; REM 5/0 -> 5.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
- MUL started, flush_i at cycle 10 -> IDLE next cycle, stall_o=0, no ready_o. Separately, rst_n=0 at cycle 20 mid-op -> all outputs 0, a new request then completes normally in 33 cycles.
